// File: rtl/computation_layer_lanes_pkg.sv
// Field, gate-function and FSM definitions shared by the layer, its lanes
// and its bus interface; also index-width and lane-to-gate helpers.
package computation_layer_lanes_pkg;

    localparam int F_NBITS = 8;
    localparam logic [F_NBITS-1:0] F_PRIME = 8'd251;

    typedef logic [F_NBITS-1:0] felem_t;

    localparam int GATEFN_W = 2;

    typedef enum logic [GATEFN_W-1:0] {
        GATEFN_ADD = 2'd0,
        GATEFN_MUL = 2'd1,
        GATEFN_SUB = 2'd2,
        GATEFN_MUX = 2'd3
    } gatefn_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } layer_state_e;

    // Index width that stays >= 1 for single-entry tables.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pass_count(input int ng, input int nl);
        return (ng + nl - 1) / nl;
    endfunction

    function automatic int lane_gate(input int pass, input int lane,
                                     input int nl);
        return pass * nl + lane;
    endfunction

    // Operands are assumed already reduced (< F_PRIME).
    function automatic felem_t f_add(input felem_t a, input felem_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, F_PRIME}) ? F_NBITS'(s - {1'b0, F_PRIME})
                                      : F_NBITS'(s);
    endfunction

    function automatic felem_t f_sub(input felem_t a, input felem_t b);
        return (a >= b) ? a - b
                        : F_NBITS'({1'b0, a} + {1'b0, F_PRIME} - {1'b0, b});
    endfunction

    function automatic felem_t f_mul(input felem_t a, input felem_t b);
        logic [2*F_NBITS-1:0] pr;
        pr = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        return F_NBITS'(pr % {{F_NBITS{1'b0}}, F_PRIME});
    endfunction

endpackage

// File: rtl/computation_layer_lanes_if.sv
// Bus between a layer and its user: start pulse, inputs, selects, status
// and results. master = user side, slave = layer side.
interface computation_layer_lanes_if
    import computation_layer_lanes_pkg::*;
#(
    parameter int ngates   = 8,
    parameter int ninputs  = 8,
    parameter int nmuxsels = 1
) ();

    logic                       en;
    felem_t [ninputs-1:0]       v_in;
    logic   [nmuxsels-1:0]      mux_sel;
    logic                       ready;
    logic                       ready_pulse;
    felem_t [ngates-1:0]        v_out;

    modport master (
        output en, v_in, mux_sel,
        input  ready, ready_pulse, v_out
    );

    modport slave (
        input  en, v_in, mux_sel,
        output ready, ready_pulse, v_out
    );

endinterface

// File: rtl/computation_layer_lanes_lane.sv
// computation_lane: one field gate evaluator with a runtime function code.
// Ports: clk, rstb, start, in0, in1, sel, fn -> done, out (registered).
module computation_lane
    import computation_layer_lanes_pkg::*;
(
    input  logic    clk,
    input  logic    rstb,
    input  logic    start,
    input  felem_t  in0,
    input  felem_t  in1,
    input  logic    sel,
    input  gatefn_e fn,
    output logic    done,
    output felem_t  out
);

    felem_t out_d;
    felem_t out_q;
    logic   done_q;

    always_comb begin
        out_d = '0;
        unique case (fn)
            GATEFN_ADD: out_d = f_add(in0, in1);
            GATEFN_MUL: out_d = f_mul(in0, in1);
            GATEFN_SUB: out_d = f_sub(in0, in1);
            GATEFN_MUX: out_d = sel ? in1 : in0;
            default:    out_d = '0;
        endcase
    end

    // done stays set once a result is held; a reset aborts the lane.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            out_q  <= out_d;
            done_q <= 1'b1;
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: rtl/computation_layer_lanes.sv
// computation_layer_lanes: evaluates ngates field gates on nlanes shared
// lanes over npasses passes. Ports: clk, rstb, bus (slave: en, v_in,
// mux_sel -> ready, ready_pulse, v_out). Optional macro
// COMPUTATION_LAYER_INCAPTURE_EN snapshots v_in/mux_sel on accepted en.
module computation_layer_lanes
    import computation_layer_lanes_pkg::*;
#(
    parameter int ngates   = 8,
    parameter int ninputs  = 8,
    parameter int nlanes   = 2,
    parameter int nmuxsels = 1,
    parameter int ninbits  = idx_bits(ninputs),
    parameter int nmuxbits = idx_bits(nmuxsels),
    parameter int npasses  = pass_count(ngates, nlanes),
    parameter logic [ngates*GATEFN_W-1:0] gates_fn  = '0,
    parameter logic [ngates*ninbits-1:0]  gates_in0 = '0,
    parameter logic [ngates*ninbits-1:0]  gates_in1 = '0,
    parameter logic [ngates*nmuxbits-1:0] gates_mux = '0
) (
    input logic clk,
    input logic rstb,
    computation_layer_lanes_if.slave bus
);

    localparam int GW = idx_bits(ngates);
    localparam int PW = idx_bits(npasses);

    if (ninbits != idx_bits(ninputs) || nmuxbits != idx_bits(nmuxsels) ||
        npasses != pass_count(ngates, nlanes)) begin : g_bad_derived
        $error("derived parameter overridden");
    end

    if (nlanes < 1 || nlanes > ngates) begin : g_bad_lanes
        $error("nlanes out of range");
    end

    layer_state_e         state_q;
    logic [PW-1:0]        pass_q;
    logic                 ready_q;
    logic                 rpulse_q;
    felem_t [ngates-1:0]  vout_q;

    felem_t [ninputs-1:0] v_src;
    logic [nmuxsels-1:0]  sel_src;

`ifdef COMPUTATION_LAYER_INCAPTURE_EN
    felem_t [ninputs-1:0] vin_q;
    logic [nmuxsels-1:0]  msel_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vin_q  <= '0;
            msel_q <= '0;
        end else if (state_q == ST_IDLE && bus.en) begin
            vin_q  <= bus.v_in;
            msel_q <= bus.mux_sel;
        end
    end

    assign v_src   = vin_q;
    assign sel_src = msel_q;
`else
    assign v_src   = bus.v_in;
    assign sel_src = bus.mux_sel;
`endif

    // Per-gate tables unpacked once so lanes index them by gate number.
    gatefn_e              fn_tab  [ngates];
    logic [ninbits-1:0]   in0_tab [ngates];
    logic [ninbits-1:0]   in1_tab [ngates];
    logic [nmuxbits-1:0]  mux_tab [ngates];

    for (genvar g = 0; g < ngates; g++) begin : g_tab
        assign fn_tab[g]  = gatefn_e'(gates_fn[g*GATEFN_W +: GATEFN_W]);
        assign in0_tab[g] = gates_in0[g*ninbits +: ninbits];
        assign in1_tab[g] = gates_in1[g*ninbits +: ninbits];
        assign mux_tab[g] = gates_mux[g*nmuxbits +: nmuxbits];

        if (gates_in0[g*ninbits +: ninbits] >= ninputs ||
            gates_in1[g*ninbits +: ninbits] >= ninputs) begin : g_bad_in
            $error("gate input index out of range");
        end
        if (gates_mux[g*nmuxbits +: nmuxbits] >= nmuxsels) begin : g_bad_mux
            $error("gate mux index out of range");
        end
    end

    logic [nlanes-1:0] act;
    logic [nlanes-1:0] done;
    logic [GW-1:0]     gsel [nlanes];
    felem_t            lout [nlanes];
    logic              all_done;
    logic              last_pass;

    for (genvar l = 0; l < nlanes; l++) begin : g_lane
        int gate_n;

        // Lanes past the last gate idle and count as done.
        assign gate_n  = lane_gate(int'(pass_q), l, nlanes);
        assign act[l]  = gate_n < ngates;
        assign gsel[l] = act[l] ? GW'(gate_n) : '0;

        computation_lane u_lane (
            .clk   (clk),
            .rstb  (rstb),
            .start (state_q == ST_ISSUE && act[l]),
            .in0   (v_src[in0_tab[gsel[l]]]),
            .in1   (v_src[in1_tab[gsel[l]]]),
            .sel   (sel_src[mux_tab[gsel[l]]]),
            .fn    (fn_tab[gsel[l]]),
            .done  (done[l]),
            .out   (lout[l])
        );
    end

    assign all_done  = &(done | ~act);
    assign last_pass = (int'(pass_q) == npasses - 1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            pass_q   <= '0;
            ready_q  <= 1'b1;
            rpulse_q <= 1'b0;
            vout_q   <= '0;
        end else begin
            rpulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        state_q <= ST_ISSUE;
                        pass_q  <= '0;
                        ready_q <= 1'b0;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (all_done) state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    for (int l = 0; l < nlanes; l++) begin
                        if (act[l]) vout_q[gsel[l]] <= lout[l];
                    end
                    if (last_pass) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        rpulse_q <= 1'b1;
                    end else begin
                        state_q <= ST_ISSUE;
                        pass_q  <= pass_q + PW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.ready_pulse = rpulse_q;
    assign bus.v_out       = vout_q;

endmodule

// File: tb/tb_computation_layer_lanes.sv
// Directed bench: four layer instances (4g/2l, 3g/2l, 4g/1l, 4g/4l) fed
// identical stimulus, checked against hand-computed mod-251 results.
module tb_computation_layer_lanes;
    import computation_layer_lanes_pkg::*;

    localparam logic [7:0]  FN4  = {GATEFN_MUX, GATEFN_SUB, GATEFN_MUL, GATEFN_ADD};
    localparam logic [5:0]  FN3  = {GATEFN_SUB, GATEFN_MUL, GATEFN_ADD};
    localparam logic [11:0] I0_4 = {3'd6, 3'd4, 3'd2, 3'd0};
    localparam logic [11:0] I1_4 = {3'd7, 3'd5, 3'd3, 3'd1};
    localparam logic [8:0]  I0_3 = {3'd4, 3'd2, 3'd0};
    localparam logic [8:0]  I1_3 = {3'd5, 3'd3, 3'd1};

    // Pattern A: add(3,4) mul(5,6) sub(2,5) mux(sel=1: 8,9)
    localparam logic [63:0] VA  = {8'd9, 8'd8, 8'd5, 8'd2, 8'd6, 8'd5, 8'd4, 8'd3};
    localparam logic [63:0] EA4 = {32'd0, 8'd9, 8'd248, 8'd30, 8'd7};
    localparam logic [63:0] EA3 = {40'd0, 8'd248, 8'd30, 8'd7};
    // Pattern B (sel=0): 200+100, 250*2, 0-1, mux -> in0=17
    localparam logic [63:0] VB  = {8'd33, 8'd17, 8'd1, 8'd0, 8'd2, 8'd250, 8'd100, 8'd200};
    localparam logic [63:0] EB4 = {32'd0, 8'd17, 8'd250, 8'd249, 8'd49};
    localparam logic [63:0] EB3 = {40'd0, 8'd250, 8'd249, 8'd49};

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    computation_layer_lanes_if #(.ngates(4), .ninputs(8), .nmuxsels(1)) i4 ();
    computation_layer_lanes_if #(.ngates(3), .ninputs(8), .nmuxsels(1)) i3 ();
    computation_layer_lanes_if #(.ngates(4), .ninputs(8), .nmuxsels(1)) i1 ();
    computation_layer_lanes_if #(.ngates(4), .ninputs(8), .nmuxsels(1)) iF ();

    computation_layer_lanes #(
        .ngates(4), .ninputs(8), .nlanes(2), .nmuxsels(1),
        .gates_fn(FN4), .gates_in0(I0_4), .gates_in1(I1_4), .gates_mux(4'b0)
    ) d4 (.clk(clk), .rstb(rstb), .bus(i4));

    computation_layer_lanes #(
        .ngates(3), .ninputs(8), .nlanes(2), .nmuxsels(1),
        .gates_fn(FN3), .gates_in0(I0_3), .gates_in1(I1_3), .gates_mux(3'b0)
    ) d3 (.clk(clk), .rstb(rstb), .bus(i3));

    computation_layer_lanes #(
        .ngates(4), .ninputs(8), .nlanes(1), .nmuxsels(1),
        .gates_fn(FN4), .gates_in0(I0_4), .gates_in1(I1_4), .gates_mux(4'b0)
    ) d1 (.clk(clk), .rstb(rstb), .bus(i1));

    computation_layer_lanes #(
        .ngates(4), .ninputs(8), .nlanes(4), .nmuxsels(1),
        .gates_fn(FN4), .gates_in0(I0_4), .gates_in1(I1_4), .gates_mux(4'b0)
    ) dF (.clk(clk), .rstb(rstb), .bus(iF));

    int n_cmp = 0;
    int n_bad = 0;
    int lat4, lat3, lat1, latF;
    int pc4, pc3, pc1, pcF;
    int hi4;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [63:0] v, input logic ms);
        i4.v_in = v; i3.v_in = v; i1.v_in = v; iF.v_in = v;
        i4.mux_sel = ms; i3.mux_sel = ms; i1.mux_sel = ms; iF.mux_sel = ms;
    endtask

    task automatic set_en(input logic b);
        i4.en = b; i3.en = b; i1.en = b; iF.en = b;
    endtask

    // Pulse en, then watch 20 cycles: latency in cycles from the en edge,
    // pulse counts, and ready seen high while d4 should be busy.
    task automatic run(input int repulse, input bit swap,
                       input logic [63:0] swap_v, input logic swap_ms);
        lat4 = 0; lat3 = 0; lat1 = 0; latF = 0;
        pc4 = 0; pc3 = 0; pc1 = 0; pcF = 0; hi4 = 0;
        @(negedge clk);
        set_en(1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) set_en(1'b0);
            if (swap && k == 1) set_in(swap_v, swap_ms);
            if (repulse != 0 && k == repulse) set_en(1'b1);
            if (repulse != 0 && k == repulse + 1) set_en(1'b0);
            if (i4.ready_pulse) begin pc4++; if (lat4 == 0) lat4 = k; end
            if (i3.ready_pulse) begin pc3++; if (lat3 == 0) lat3 = k; end
            if (i1.ready_pulse) begin pc1++; if (lat1 == 0) lat1 = k; end
            if (iF.ready_pulse) begin pcF++; if (latF == 0) latF = k; end
            if (k < 7 && i4.ready !== 1'b0) hi4++;
        end
    endtask

    task automatic check_run(input string tag, input logic [63:0] e4,
                             input logic [63:0] e3);
        $display("-- checking %s", tag);
        chk("d4_vout",     64'(i4.v_out), e4);
        chk("d4_pulses",   64'(pc4), 64'd1);
        chk("d4_latency",  64'(lat4), 64'd7);
        chk("d4_busy_rdy", 64'(hi4), 64'd0);
        chk("d4_ready",    64'(i4.ready), 64'd1);
        chk("d3_vout",     64'(i3.v_out), e3);
        chk("d3_pulses",   64'(pc3), 64'd1);
        chk("d3_latency",  64'(lat3), 64'd7);
        chk("d1_vout",     64'(i1.v_out), e4);
        chk("d1_pulses",   64'(pc1), 64'd1);
        chk("d1_latency",  64'(lat1), 64'd13);
        chk("dF_vout",     64'(iF.v_out), e4);
        chk("dF_pulses",   64'(pcF), 64'd1);
        chk("dF_latency",  64'(latF), 64'd4);
        chk("d1_vs_dF",    64'(i1.v_out), 64'(iF.v_out));
    endtask

    initial begin
        rstb = 1'b1;
        set_en(1'b0);
        set_in(64'd0, 1'b0);
        #2 rstb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_d4_vout",  64'(i4.v_out), 64'd0);
        chk("rst_d4_ready", 64'(i4.ready), 64'd1);
        chk("rst_d4_pulse", 64'(i4.ready_pulse), 64'd0);
        chk("rst_d3_vout",  64'(i3.v_out), 64'd0);
        chk("rst_d1_ready", 64'(i1.ready), 64'd1);
        rstb = 1'b1;

        set_in(VA, 1'b1);
        run(0, 1'b0, 64'd0, 1'b0);
        check_run("pattern A", EA4, EA3);

        // en pulsed again during WAIT of the first pass is ignored
        set_in(VB, 1'b0);
        run(2, 1'b0, 64'd0, 1'b0);
        check_run("pattern B, en re-pulsed", EB4, EB3);

        // reset in WAIT of the second pass aborts the run
        set_in(VA, 1'b1);
        @(negedge clk);
        set_en(1'b1);
        @(negedge clk);
        set_en(1'b0);
        repeat (4) @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("mid_rst_d4_vout",  64'(i4.v_out), 64'd0);
        chk("mid_rst_d4_ready", 64'(i4.ready), 64'd1);
        chk("mid_rst_d4_pulse", 64'(i4.ready_pulse), 64'd0);
        chk("mid_rst_d3_vout",  64'(i3.v_out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        pc4 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (i4.ready_pulse) pc4++;
        end
        chk("post_rst_pulses", 64'(pc4), 64'd0);
        chk("post_rst_ready",  64'(i4.ready), 64'd1);
        chk("post_rst_vout",   64'(i4.v_out), 64'd0);

        run(0, 1'b0, 64'd0, 1'b0);
        check_run("pattern A after reset", EA4, EA3);

`ifdef COMPUTATION_LAYER_INCAPTURE_EN
        // inputs swapped the cycle after en: results follow the snapshot
        set_in(VB, 1'b0);
        run(0, 1'b1, VA, 1'b1);
        check_run("captured inputs", EB4, EB3);
`else
        $display("note: input change while busy not checked in this build");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/computation_layer_lanes.md
COMPUTATION_LAYER_LANES -- requirements
Module: computation_layer_lanes

Interface
REQ-001 SHALL have parameter ngates, default 8: gates in the layer.
REQ-002 SHALL have parameter ninputs, default 8: entries in v_in.
REQ-003 SHALL have parameter nlanes, default 2: shared gate evaluators, 1..ngates.
REQ-004 SHALL have parameter nmuxsels, default 1: entries in mux_sel.
REQ-005 SHALL have parameters gates_fn, gates_in0, gates_in1 and gates_mux, default 0: packed per-gate function code, input indices and mux_sel index.
REQ-006 SHALL have derived parameters ninbits, nmuxbits and npasses = ceil(ngates/nlanes); an override SHALL fail elaboration.
REQ-007 SHALL have clk, input, 1: clock.
REQ-008 SHALL have rstb, input, 1: asynchronous active-low reset.
REQ-009 SHALL have en, input, 1: start pulse.
REQ-010 SHALL have v_in, input, ninputs x F_NBITS: layer inputs.
REQ-011 SHALL have mux_sel, input, nmuxsels: mux-gate selects.
REQ-012 SHALL have ready, output, 1: idle with v_out valid.
REQ-013 SHALL have ready_pulse, output, 1: one-cycle completion strobe.
REQ-014 SHALL have v_out, output, ngates x F_NBITS: registered gate results.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT and WRITE.
- IDLE: en=1 -> ISSUE.
- ISSUE, one cycle: pass p starts lane l on gate p*nlanes+l -> WAIT.
- WAIT: all active lanes done -> WRITE.
- WRITE: results go to v_out; p<npasses-1 -> ISSUE with p+1, else -> IDLE.
REQ-016 SHALL hold ready low from the cycle after accepted en until the WRITE of the final pass; ready SHALL be high in the following cycle.
REQ-017 SHALL assert ready_pulse for exactly the one cycle in which ready rises.
REQ-018 SHALL ignore en while ready=0, with no restart and no queueing.
REQ-019 SHALL treat lanes whose gate index is >= ngates in the last partial pass as done immediately; their results SHALL be discarded.
REQ-020 SHALL resolve each lane's function, operands and select at runtime from the per-gate parameter tables, indexed by pass counter.
REQ-021 SHALL reduce all arithmetic modulo the field prime; sub SHALL wrap, e.g. 2-5 = p-3; mux SHALL output in1 when its mux_sel bit is 1, else in0.
REQ-022 SHALL update each v_out entry only in the WRITE of its own pass; other entries SHALL hold.
REQ-023 SHALL elaborate with nlanes=ngates (npasses=1) and with nlanes=1.
REQ-024 SHALL fail elaboration on any gate input index >= ninputs or any mux index >= nmuxsels.

Reset
REQ-025 SHALL, while rstb=0, force state IDLE, pass counter 0, all v_out 0, ready=1 and ready_pulse=0.
REQ-026 SHALL abort lanes when reset is applied mid-operation; no ready_pulse SHALL follow reset release.

Configuration
REQ-027 SHALL, with COMPUTATION_LAYER_INCAPTURE_EN defined, register all v_in and mux_sel on accepted en and evaluate from the copy, so inputs may change freely while busy.
REQ-028 SHALL, without COMPUTATION_LAYER_INCAPTURE_EN, read v_in and mux_sel directly; the caller SHALL hold them stable until ready_pulse.

Structure
REQ-029 SHALL take GATEFN encodings and width and F_NBITS from the shared gate-function and field definitions; FSM state enum and lane-index helpers SHALL live in a shared package.
REQ-030 SHALL use exactly one sub-module, computation_lane, replicated nlanes times: runtime-function field gate with start, in0, in1, sel, fn, done and out, reusing the existing field add/mul units.

Verification
REQ-031 SHALL cover: ngates=4, nlanes=2, gates add(3,4), mul(5,6), sub(2,5), mux(sel=1, 8, 9), en pulse -> v_out={7,30,p-3,9}, exactly one ready_pulse, ready low for the whole run.
REQ-032 SHALL cover: ngates=3, nlanes=2 -> 2 passes, v_out[2] correct, discarded lane has no effect on v_out.
REQ-033 SHALL cover: en re-pulsed during WAIT -> single run, single ready_pulse.
REQ-034 SHALL cover: rstb low in WAIT of pass 1 -> v_out all 0, ready=1, no ready_pulse after release; a new en then completes normally.
REQ-035 SHALL cover, with COMPUTATION_LAYER_INCAPTURE_EN: v_in changed in the cycle after en -> results from the original values; without the macro, same test -> mismatch is documented and not checked.
REQ-036 SHALL cover: nlanes=1 versus nlanes=ngates on identical stimulus -> identical v_out.
